// File: rtl/riscv_pkg.sv
// Shared constants for the data-memory path: master identifiers and default bus widths.
package riscv_pkg;

    localparam int   DMEM_AW    = 32;
    localparam int   DMEM_DW    = 32;
    localparam int   WAIT_W     = 4;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_LDR = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Grant selection between the CPU port and the loader port: CPU wins ties
// unless the loader has already been refused max_wait consecutive cycles.
module dmem_rr_pick
    import riscv_pkg::*;
(
    input  logic              req0,
    input  logic              req1,
    input  logic [WAIT_W-1:0] wait_cnt,
    input  logic [WAIT_W-1:0] max_wait,
    output logic              gnt0,
    output logic              gnt1
);

    logic starved;

    always_comb begin
        starved = (wait_cnt == max_wait);
        gnt1    = req1 & (~req0 | starved);
        gnt0    = req0 & ~gnt1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-ported data RAM: registered command stage,
// fixed-latency read return steered to the issuing master, loader starvation guard.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic          pick_gnt0, pick_gnt1;

    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          owner_q,     owner_d;
    logic          rd_pend_q,   rd_pend_d;
    logic          rd_owner_q,  rd_owner_d;
    logic [DW-1:0] rdata0_q,    rdata0_d;
    logic [DW-1:0] rdata1_q,    rdata1_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    dmem_rr_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .wait_cnt (wait_cnt_q),
        .max_wait (MAX_WAIT_C),
        .gnt0     (pick_gnt0),
        .gnt1     (pick_gnt1)
    );

    // Grants are combinational, so they must be masked while reset is held.
    always_comb begin
        m0_gnt = pick_gnt0 & reset;
        m1_gnt = pick_gnt1 & reset;
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        if (m0_gnt) begin
            mem_en_d    = 1'b1;
            mem_we_d    = m0_we;
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
            owner_d     = MASTER_CPU;
        end else if (m1_gnt) begin
            mem_en_d    = 1'b1;
            mem_we_d    = m1_we;
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
            owner_d     = MASTER_LDR;
        end
    end

    // RAM data is valid the cycle after a read strobe; forward it live and keep a copy.
    always_comb begin
        rd_pend_d  = mem_en_q & ~mem_we_q;
        rd_owner_d = owner_q;
        m0_rvalid  = rd_pend_q & (rd_owner_q == MASTER_CPU);
        m1_rvalid  = rd_pend_q & (rd_owner_q == MASTER_LDR);
        rdata0_d   = m0_rvalid ? mem_rdata : rdata0_q;
        rdata1_d   = m1_rvalid ? mem_rdata : rdata1_q;
        m0_rdata   = rdata0_d;
        m1_rdata   = rdata1_d;
    end

    always_comb begin
        wait_cnt_d = '0;
        if (m1_req & ~m1_gnt) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            wait_cnt_q  <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        owner     = owner_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_en, mem_we, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = 32'h9E37_79B9 * 32'(i + 1);
        case (i)
            0: w = 32'hC0DE_0000;
            1: w = 32'hC0DE_0004;
            2: w = 32'hC0DE_0008;
            4: w = 32'hDEAD_BEEF;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // The data RAM: one-cycle registered read, write on strobe.
    initial begin
        logic [31:0] ram [16];
        for (int i = 0; i < 16; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr[5:2]] = mem_wdata;
                else        mem_rdata <= ram[mem_addr[5:2]];
            end
        end
    end

    // Transaction-level model: what is on the memory bus, what read is in
    // flight, what each master last received, and how long m1 has been refused.
    logic        exp_g0 = 1'b0, exp_g1 = 1'b0;
    logic        c_en = 1'b0, c_we = 1'b0, c_owner = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        p_v = 1'b0, p_owner = 1'b0;
    logic [31:0] p_data = '0;
    logic [31:0] hold [2] = '{32'h0, 32'h0};
    int          refused = 0;

    initial begin
        logic [31:0] mram [16];
        for (int i = 0; i < 16; i++) mram[i] = init_word(i);
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                c_en = 0; c_we = 0; c_owner = 0; c_addr = 0; c_wdata = 0;
                p_v = 0; p_owner = 0; p_data = 0;
                hold[0] = 0; hold[1] = 0;
                refused = 0;
            end else begin
                if (p_v) hold[p_owner] = p_data;
                p_v     = c_en && !c_we;
                p_owner = c_owner;
                p_data  = mram[c_addr[5:2]];
                if (c_en && c_we) mram[c_addr[5:2]] = c_wdata;
                refused = (m1_req && !exp_g1) ? refused + 1 : 0;
                if (exp_g0) begin
                    c_en = 1; c_we = m0_we; c_addr = m0_addr; c_wdata = m0_wdata; c_owner = 0;
                end else if (exp_g1) begin
                    c_en = 1; c_we = m1_we; c_addr = m1_addr; c_wdata = m1_wdata; c_owner = 1;
                end else begin
                    c_en = 0; c_we = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_g0 = 0;
                exp_g1 = 0;
            end else begin
                exp_g1 = m1_req && (!m0_req || refused >= MAX_WAIT);
                exp_g0 = m0_req && !exp_g1;
            end
            chk("m0_gnt", m0_gnt, exp_g0);
            chk("m1_gnt", m1_gnt, exp_g1);
            chk("mem_en", mem_en, c_en);
            chk("mem_we", mem_we, c_we);
            chk("mem_addr", mem_addr, c_addr);
            chk("mem_wdata", mem_wdata, c_wdata);
            chk("owner", owner, c_owner);
            chk("m0_rvalid", m0_rvalid, p_v && p_owner == 0);
            chk("m1_rvalid", m1_rvalid, p_v && p_owner == 1);
            chk("m0_rdata", m0_rdata, (p_v && p_owner == 0) ? p_data : hold[0]);
            chk("m1_rdata", m1_rdata, (p_v && p_owner == 1) ? p_data : hold[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            m0_req = 0;
            m1_req = 0;
        end
    endtask

    initial begin
        logic [31:0] seq_addr [3];
        logic [31:0] seq_data [3];
        logic        g0, g1;
        seq_addr = '{32'h0, 32'h4, 32'h8};
        seq_data = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008};

        // Requests during reset must not be granted.
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        tick();
        reset = 1; m0_req = 0; m1_req = 0;
        idle(2);

        // m0 read of 0x10 alone.
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        @(negedge clk);
        chk("t1_m0_gnt", m0_gnt, 1);
        tick(); m0_req = 0;
        @(negedge clk);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_owner", owner, 0);
        tick();
        @(negedge clk);
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        idle(2);

        // m1 write alone.
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("t2_m1_gnt", m1_gnt, 1);
        tick(); m1_req = 0;
        @(negedge clk);
        chk("t2_mem_en", mem_en, 1);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("t2_owner", owner, 1);
        tick();
        @(negedge clk);
        chk("t2_m0_rvalid", m0_rvalid, 0);
        chk("t2_m1_rvalid", m1_rvalid, 0);
        idle(2);

        // Both masters saturating: m1 gets every fifth slot.
        for (int i = 0; i < 10; i++) begin
            m0_req = 1; m0_we = 0; m0_addr = 32'h10;
            m1_req = 1; m1_we = 1; m1_addr = 32'h3C; m1_wdata = 32'h55AA_0000 + 32'(i / 5);
            @(negedge clk);
            chk("t3_m1_gnt", m1_gnt, (i % 5) == 4);
            chk("t3_m0_gnt", m0_gnt, (i % 5) != 4);
            tick();
        end
        m0_req = 0; m1_req = 0;
        idle(3);

        // Back-to-back m0 reads of 0x0, 0x4, 0x8.
        for (int i = 0; i < 5; i++) begin
            m0_req = (i < 3); m0_we = 0;
            if (i < 3) m0_addr = seq_addr[i];
            @(negedge clk);
            if (i < 3) chk("t4_m0_gnt", m0_gnt, 1);
            if (i >= 1 && i <= 3) begin
                chk("t4_mem_en", mem_en, 1);
                chk("t4_mem_addr", mem_addr, seq_addr[i-1]);
            end
            if (i >= 2) begin
                chk("t4_m0_rvalid", m0_rvalid, 1);
                chk("t4_m0_rdata", m0_rdata, seq_data[i-2]);
            end
            tick();
        end
        m0_req = 0;
        idle(2);

        // Reset pulled mid-read: nothing comes back, next grant is normal.
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        @(negedge clk);
        chk("t5_m0_gnt", m0_gnt, 1);
        tick(); m0_req = 0; reset = 0;
        @(negedge clk);
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_m0_rvalid", m0_rvalid, 0);
        tick(); reset = 1; m0_req = 1; m0_addr = 32'h4;
        @(negedge clk);
        chk("t5_post_m0_gnt", m0_gnt, 1);
        chk("t5_post_m0_rvalid", m0_rvalid, 0);
        chk("t5_post_mem_en", mem_en, 0);
        tick(); m0_req = 0;
        tick();
        @(negedge clk);
        chk("t5_post_m0_rdata", m0_rdata, 32'hC0DE_0004);
        idle(2);

        // m1 withdraws after two refusals; counting restarts from zero.
        for (int i = 0; i < 8; i++) begin
            m0_req = 1; m0_we = 0; m0_addr = 32'h8;
            m1_req = (i != 2); m1_we = 0; m1_addr = 32'h4;
            @(negedge clk);
            if (i != 2) chk("t6_m1_gnt", m1_gnt, i == 7);
            tick();
        end
        m0_req = 0; m1_req = 0;
        idle(3);

        // Randomized traffic obeying the hold-until-grant rule.
        g0 = 0; g1 = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                m0_req = 0; m1_req = 0;
                tick();
                reset = 1;
            end else begin
                if (m0_req && !g0) begin
                    if ($urandom_range(0, 9) == 0) m0_req = 0;
                end else begin
                    m0_req   = ($urandom_range(0, 9) < 7);
                    m0_we    = $urandom_range(0, 1) == 1;
                    m0_addr  = 32'($urandom_range(0, 15)) << 2;
                    m0_wdata = $urandom;
                end
                if (m1_req && !g1) begin
                    if ($urandom_range(0, 19) == 0) m1_req = 0;
                end else begin
                    m1_req   = ($urandom_range(0, 9) < 6);
                    m1_we    = $urandom_range(0, 1) == 1;
                    m1_addr  = 32'($urandom_range(0, 15)) << 2;
                    m1_wdata = $urandom;
                end
            end
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            tick();
        end
        m0_req = 0; m1_req = 0;
        idle(4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
